score_keeper: RTL and testbench



---
 rtl/score_keeper_pkg.sv | 28 ++
 rtl/score_keeper_bcd_counter.sv | 40 ++++
 rtl/score_keeper.sv | 117 +++++++++++
 tb/tb_score_keeper.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/score_keeper_pkg.sv
// Shared encodings and BCD helpers for the two-player score keeper.
package score_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2,
    ST_BAD  = 2'd3
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [2:0] TENS_MAX = 3'd7;

  // Returns {tens, ones} of the incremented score, holding at 79.
  function automatic logic [6:0] bcd_inc(input logic [2:0] tens, input logic [3:0] ones);
    if (tens == TENS_MAX && ones == ONES_MAX)
      return {tens, ones};
    else if (ones == ONES_MAX)
      return {tens + 3'd1, 4'd0};
    else
      return {tens, ones + 4'd1};
  endfunction

endpackage

// File: rtl/score_keeper_bcd_counter.sv
// Two-digit saturating BCD score counter (0..79); clear wins over increment.
module bcd_counter
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] ones,
  output logic [2:0] tens
);

  logic [3:0] ones_q, ones_d;
  logic [2:0] tens_q, tens_d;

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 3'd0;
    end else if (inc) begin
      {tens_d, ones_d} = bcd_inc(tens_q, ones_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= 4'd0;
      tens_q <= 3'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;

endmodule

// File: rtl/score_keeper.sv
// Two-player BCD score keeper: goal accounting, post-goal hold-off with serve
// pulse, and game-over / winner detection.
module score_keeper
  import score_pkg::*;
#(
  parameter int WIN_SCORE      = 7,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int HOLD_W         = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       p1_goal,
  input  logic       p2_goal,
  output logic [3:0] p1_ones,
  output logic [2:0] p1_tens,
  output logic [3:0] p2_ones,
  output logic [2:0] p2_tens,
  output logic       serve,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [1:0] state
);

  localparam logic [2:0]        WIN_TENS  = 3'(WIN_SCORE / 10);
  localparam logic [3:0]        WIN_ONES  = 4'(WIN_SCORE % 10);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);

  state_e            state_q;
  logic [HOLD_W-1:0] hold_q;
  logic              serve_q;
  logic              game_over_q;
  logic [1:0]        winner_q;

  logic       goal_ok, p1_inc, p2_inc, p1_win, p2_win;
  logic [6:0] p1_nxt, p2_nxt;

  // A goal counts only in PLAY, from exactly one player, and not under new_game.
  assign goal_ok = (state_q == ST_PLAY) && (p1_goal ^ p2_goal) && !new_game;
  assign p1_inc  = goal_ok && p1_goal;
  assign p2_inc  = goal_ok && p2_goal;

  assign p1_nxt = bcd_inc(p1_tens, p1_ones);
  assign p2_nxt = bcd_inc(p2_tens, p2_ones);
  assign p1_win = (p1_nxt[6:4] == WIN_TENS) && (p1_nxt[3:0] == WIN_ONES);
  assign p2_win = (p2_nxt[6:4] == WIN_TENS) && (p2_nxt[3:0] == WIN_ONES);

  bcd_counter u_p1 (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (new_game),
    .inc  (p1_inc),
    .ones (p1_ones),
    .tens (p1_tens)
  );

  bcd_counter u_p2 (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (new_game),
    .inc  (p2_inc),
    .ones (p2_ones),
    .tens (p2_tens)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLAY;
      hold_q      <= '0;
      serve_q     <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= WIN_NONE;
    end else begin
      serve_q <= 1'b0;
      if (new_game) begin
        state_q     <= ST_PLAY;
        hold_q      <= '0;
        game_over_q <= 1'b0;
        winner_q    <= WIN_NONE;
      end else begin
        case (state_q)
          ST_PLAY: begin
            if ((p1_inc && p1_win) || (p2_inc && p2_win)) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
              winner_q    <= p1_inc ? WIN_P1 : WIN_P2;
            end else if (p1_inc || p2_inc) begin
              state_q <= ST_HOLD;
              hold_q  <= HOLD_LOAD;
            end
          end
          ST_HOLD: begin
            if (hold_q == '0) begin
              serve_q <= 1'b1;
              state_q <= ST_PLAY;
            end else begin
              hold_q <= hold_q - HOLD_W'(1);
            end
          end
          ST_OVER: ;
          default: begin
            state_q     <= ST_PLAY;
            hold_q      <= '0;
            game_over_q <= 1'b0;
            winner_q    <= WIN_NONE;
          end
        endcase
      end
    end
  end

  assign serve     = serve_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;
  assign state     = state_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: directed scenarios plus random goal traffic
// checked against an integer-score reference model.
module tb_score_keeper;

  localparam int WIN = 12;
  localparam int HO  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0, p1_goal = 1'b0, p2_goal = 1'b0;
  logic [3:0] p1_ones, p2_ones;
  logic [2:0] p1_tens, p2_tens;
  logic       serve, game_over;
  logic [1:0] winner, state;

  score_keeper #(.WIN_SCORE(WIN), .HOLDOFF_CYCLES(HO), .HOLD_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .p1_goal(p1_goal), .p2_goal(p2_goal),
    .p1_ones(p1_ones), .p1_tens(p1_tens), .p2_ones(p2_ones), .p2_tens(p2_tens),
    .serve(serve), .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p1; int p2; int srv; int over; int win; int st;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  int serves_seen = 0, serves_exp = 0;
  // Reference model: plain integer scores, mode 0 play / 1 hold / 2 over.
  int m_p1, m_p2, m_mode, m_wait, m_win;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_mode = 0; m_wait = 0; m_win = 0;
  endtask

  task automatic step(input bit ng, input bit g1, input bit g2);
    exp_t e;
    int srv;
    srv = 0;
    @(negedge clk);
    new_game = ng; p1_goal = g1; p2_goal = g2;
    if (ng) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (g1 != g2) begin
        if (g1) m_p1 = (m_p1 < 79) ? m_p1 + 1 : 79;
        else    m_p2 = (m_p2 < 79) ? m_p2 + 1 : 79;
        if ((g1 && m_p1 == WIN) || (g2 && m_p2 == WIN)) begin
          m_mode = 2; m_win = g1 ? 1 : 2;
        end else begin
          m_mode = 1; m_wait = HO;
        end
      end
    end else if (m_mode == 1) begin
      m_wait--;
      if (m_wait == 0) begin srv = 1; m_mode = 0; end
    end
    e.p1 = m_p1; e.p2 = m_p2; e.srv = srv; e.over = (m_mode == 2);
    e.win = m_win; e.st = m_mode;
    q.push_back(e);
    serves_exp += srv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a new register snapshot.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && serve) serves_seen++;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("p1_ones", int'(p1_ones), e.p1 % 10);
        check("p1_tens", int'(p1_tens), e.p1 / 10);
        check("p2_ones", int'(p2_ones), e.p2 % 10);
        check("p2_tens", int'(p2_tens), e.p2 / 10);
        check("serve", int'(serve), e.srv);
        check("game_over", int'(game_over), e.over);
        check("winner", int'(winner), e.win);
        check("state", int'(state), e.st);
      end
    end
  end

  initial begin
    int s0, r;
    model_reset();
    #12;
    check("rst_p1", int'({p1_tens, p1_ones}), 0);
    check("rst_p2", int'({p2_tens, p2_ones}), 0);
    check("rst_serve", int'(serve), 0);
    check("rst_over", int'(game_over), 0);
    check("rst_winner", int'(winner), 0);
    check("rst_state", int'(state), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three player-1 goals, p2 goal injected during the second hold-off.
    step(0, 1, 0); idle(6);
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 1); idle(4);
    step(0, 1, 0); idle(6);
    check("p1_after3", int'(p1_ones), 3);
    check("p2_after3", int'(p2_ones), 0);

    // Simultaneous goals are a glitch.
    s0 = serves_seen;
    step(0, 1, 1); idle(6);
    check("glitch_no_serve", serves_seen - s0, 0);

    // new_game during HOLD at 2-1 cancels the serve.
    step(1, 0, 0);
    step(0, 1, 0); idle(6);
    step(0, 1, 0); idle(6);
    step(0, 0, 1); step(0, 0, 0);
    s0 = serves_seen;
    step(1, 0, 0); idle(8);
    check("newgame_no_serve", serves_seen - s0, 0);

    // Play to WIN_SCORE=12.
    step(1, 0, 0);
    for (int g = 1; g <= WIN; g++) begin
      step(0, 1, 0);
      if (g == 10) begin
        @(posedge clk); #3;
        check("goal10_tens", int'(p1_tens), 1);
        check("goal10_ones", int'(p1_ones), 0);
      end
      idle(6);
    end
    step(0, 0, 1); idle(3);
    check("over_winner", int'(winner), 1);

    // Asynchronous reset while in OVER.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_p1", int'({p1_tens, p1_ones}), 0);
    check("arst_over", int'(game_over), 0);
    check("arst_winner", int'(winner), 0);
    check("arst_state", int'(state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(0, 1, 0); idle(6);
    check("after_arst_p1", int'(p1_ones), 1);

    // Random traffic.
    step(1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      step(r < 2, (r >= 2 && r < 16) || (r >= 30 && r < 33),
                  (r >= 16 && r < 30) || (r >= 30 && r < 33));
    end
    idle(2);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    check("queue_drained", q.size(), 0);
    check("serve_count", serves_seen, serves_exp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
